// File: rtl/lerp2_sampler.sv
// Bilinear grid sampler: splits (sx,sy) into cell/offset, fetches 4 corners, runs lerp2 (LERP2_SAMPLER_WRAP_EN = toroidal grid).
// Latency: accept to resp_valid is 7 cycles plus interpolator latency; one request in flight.
// Backpressure: req_ready only in IDLE; resp_valid/resp_val held until resp_ready.
module lerp2_sampler #(
  parameter int WIDTH  = 32,
  parameter int FBITS  = 16,
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_sx,
  input  logic [WIDTH-1:0]  req_sy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  lerp_p0,
  output logic [WIDTH-1:0]  lerp_p1,
  output logic [WIDTH-1:0]  lerp_p2,
  output logic [WIDTH-1:0]  lerp_p3,
  output logic [WIDTH-1:0]  lerp_x,
  output logic [WIDTH-1:0]  lerp_y,
  output logic [WIDTH-1:0]  lerp_X,
  output logic [WIDTH-1:0]  lerp_Y,
  output logic              lerp_start,
  input  logic              lerp_done,
  input  logic [WIDTH-1:0]  lerp_val,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_val
);

  localparam int IW = $clog2(GRID_W);
  localparam int JW = $clog2(GRID_H);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] F0    = 4'd1;
  localparam logic [3:0] F1    = 4'd2;
  localparam logic [3:0] F2    = 4'd3;
  localparam logic [3:0] F3    = 4'd4;
  localparam logic [3:0] CAP   = 4'd5;
  localparam logic [3:0] START = 4'd6;
  localparam logic [3:0] WAIT  = 4'd7;
  localparam logic [3:0] RESP  = 4'd8;

  logic [3:0]    state;
  logic [IW-1:0] i0, i1;
  logic [JW-1:0] j0, j1;

  logic signed [WIDTH-1:0] ix_full, iy_full;
  logic [IW-1:0]           ix0, ix1;
  logic [JW-1:0]           iy0, iy1;
  logic [WIDTH-1:0]        fx, fy;

  assign ix_full = $signed(req_sx) >>> FBITS;
  assign iy_full = $signed(req_sy) >>> FBITS;

  // Grid dims are powers of two, so "last column" is the all-ones index.
  always_comb begin
    ix0 = ix_full[IW-1:0];
    iy0 = iy_full[JW-1:0];
    fx  = {{(WIDTH-FBITS){1'b0}}, req_sx[FBITS-1:0]};
    fy  = {{(WIDTH-FBITS){1'b0}}, req_sy[FBITS-1:0]};
`ifdef LERP2_SAMPLER_WRAP_EN
    ix1 = ix0 + 1'b1;
    iy1 = iy0 + 1'b1;
`else
    if (ix_full[WIDTH-1]) begin
      ix0 = '0;
      fx  = '0;
    end else if (ix_full[WIDTH-2:IW] != '0) begin
      ix0 = '1;
      fx  = '0;
    end
    if (iy_full[WIDTH-1]) begin
      iy0 = '0;
      fy  = '0;
    end else if (iy_full[WIDTH-2:JW] != '0) begin
      iy0 = '1;
      fy  = '0;
    end
    ix1 = (ix0 == '1) ? ix0 : ix0 + 1'b1;
    iy1 = (iy0 == '1) ? iy0 : iy0 + 1'b1;
`endif
  end

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [IW-1:0] i, input logic [JW-1:0] j);
    cell_addr = ADDR_W'({j, i});
  endfunction

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state)
      F0: begin mem_rd = 1'b1; mem_addr = cell_addr(i0, j0); end
      F1: begin mem_rd = 1'b1; mem_addr = cell_addr(i1, j0); end
      F2: begin mem_rd = 1'b1; mem_addr = cell_addr(i0, j1); end
      F3: begin mem_rd = 1'b1; mem_addr = cell_addr(i1, j1); end
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign lerp_start = (state == START);
  assign resp_valid = (state == RESP);
  assign lerp_X     = WIDTH'(1) << FBITS;
  assign lerp_Y     = WIDTH'(1) << FBITS;

  // Each corner lands one cycle after its read, hence the one-state skew.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i0       <= '0;
      i1       <= '0;
      j0       <= '0;
      j1       <= '0;
      lerp_x   <= '0;
      lerp_y   <= '0;
      lerp_p0  <= '0;
      lerp_p1  <= '0;
      lerp_p2  <= '0;
      lerp_p3  <= '0;
      resp_val <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          i0     <= ix0;
          i1     <= ix1;
          j0     <= iy0;
          j1     <= iy1;
          lerp_x <= fx;
          lerp_y <= fy;
          state  <= F0;
        end
        F0: state <= F1;
        F1: begin lerp_p0 <= mem_rdata; state <= F2;    end
        F2: begin lerp_p1 <= mem_rdata; state <= F3;    end
        F3: begin lerp_p2 <= mem_rdata; state <= CAP;   end
        CAP: begin lerp_p3 <= mem_rdata; state <= START; end
        START: state <= WAIT;
        WAIT: if (lerp_done) begin
          resp_val <= lerp_val;
          state    <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
